// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-port signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  // requester 0
  logic                     req0_valid;
  logic                     req0_wEn;
  logic [ADDRESS_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0]    req0_wdata;
  logic                     req0_ready;
  logic                     rsp0_valid;
  logic [DATA_WIDTH-1:0]    rsp0_rdata;

  // requester 1
  logic                     req1_valid;
  logic                     req1_wEn;
  logic [ADDRESS_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0]    req1_wdata;
  logic                     req1_ready;
  logic                     rsp1_valid;
  logic [DATA_WIDTH-1:0]    rsp1_rdata;

  // shared single-port memory
  logic                     mem_wEn;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_dataIn;
  logic [DATA_WIDTH-1:0]    mem_dataOut;

  // arbiter side
  modport slave (
    input  req0_valid, req0_wEn, req0_addr, req0_wdata,
    input  req1_valid, req1_wEn, req1_addr, req1_wdata,
    input  mem_dataOut,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_wEn, mem_addr, mem_dataIn
  );

  // requesters and memory side
  modport master (
    output req0_valid, req0_wEn, req0_addr, req0_wdata,
    output req1_valid, req1_wEn, req1_addr, req1_wdata,
    output mem_dataOut,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_wEn, mem_addr, mem_dataIn
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin two-port arbiter for one single-port sync memory (optional MEM_ARB_CONFLICT_CNT_EN conflict counter)
module mem_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
`ifdef MEM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]           conflict_cnt
`endif
);

  // favoured port on a conflict, and the outstanding read (issued last cycle)
  logic prio_q,     prio_d;
  logic rsp_pend_q, rsp_pend_d;
  logic rsp_id_q,   rsp_id_d;

  logic                     grant_any;
  logic                     grant_id;
  logic                     sel_wen;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic                     rsp_live;

  // grant decision: lone requester wins, conflicts go to prio; nothing during reset
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (!reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_any = 1'b1;
        grant_id  = prio_q;
      end else if (bus.req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  // mux the granted request onto the memory port; idle drives an address-0 read
  always_comb begin
    sel_wen   = 1'b0;
    sel_addr  = {ADDRESS_WIDTH{1'b0}};
    sel_wdata = {DATA_WIDTH{1'b0}};
    if (grant_any) begin
      if (grant_id) begin
        sel_wen   = bus.req1_wEn;
        sel_addr  = bus.req1_addr;
        sel_wdata = bus.req1_wdata;
      end else begin
        sel_wen   = bus.req0_wEn;
        sel_addr  = bus.req0_addr;
        sel_wdata = bus.req0_wdata;
      end
    end
    bus.mem_wEn    = sel_wen;
    bus.mem_addr   = sel_addr;
    bus.mem_dataIn = sel_wdata;
    bus.req0_ready = grant_any && !grant_id;
    bus.req1_ready = grant_any &&  grant_id;
  end

  // steer last cycle's read data to its issuer; reset squashes a response in flight
  always_comb begin
    rsp_live       = rsp_pend_q && !reset;
    bus.rsp0_valid = rsp_live && !rsp_id_q;
    bus.rsp1_valid = rsp_live &&  rsp_id_q;
    bus.rsp0_rdata = bus.rsp0_valid ? bus.mem_dataOut : {DATA_WIDTH{1'b0}};
    bus.rsp1_rdata = bus.rsp1_valid ? bus.mem_dataOut : {DATA_WIDTH{1'b0}};
  end

  // next state: hand priority to the other port after a grant, remember granted reads
  always_comb begin
    prio_d     = prio_q;
    rsp_pend_d = 1'b0;
    rsp_id_d   = rsp_id_q;
    if (grant_any) begin
      prio_d     = ~grant_id;
      rsp_pend_d = ~sel_wen;
      rsp_id_d   = grant_id;
    end
  end

  // arbitration and response state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q     <= 1'b0;
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

`ifdef MEM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // saturating count of cycles where both ports want the memory
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (bus.req0_valid && bus.req1_valid && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // conflict counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_q <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with behavioural memory and arbitration model
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

`ifdef MEM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .conflict_cnt(conflict_cnt));
`else
  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  // single-port synchronous memory with a backdoor loader
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bd_en = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (bus.mem_wEn) mem[bus.mem_addr] <= bus.mem_dataIn;
    else bus.mem_dataOut <= mem[bus.mem_addr];
  end

  // reference model: memory contents, last-granted priority, pending response
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            m_prio = 0;
  bit            m_pend = 0;
  int            m_id = 0;
  logic [DW-1:0] m_pdata = '0;
  int            m_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  function automatic int model_grant();
    if (reset) return -1;
    if (bus.req0_valid && bus.req1_valid) return m_prio;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_commit();
    int g;
    logic wen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    g = model_grant();
    if (reset) begin
      m_prio = 0; m_pend = 0; m_id = 0; m_cnt = 0;
      return;
    end
    if (bus.req0_valid && bus.req1_valid && m_cnt < 65535) m_cnt++;
    if (g < 0) begin
      m_pend = 0;
      return;
    end
    wen = (g == 1) ? bus.req1_wEn : bus.req0_wEn;
    a   = (g == 1) ? bus.req1_addr : bus.req0_addr;
    d   = (g == 1) ? bus.req1_wdata : bus.req0_wdata;
    m_prio = 1 - g;
    if (wen) begin
      shadow[a] = d;
      m_pend = 0;
    end else begin
      m_pend = 1; m_id = g; m_pdata = shadow[a];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_req(input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.req0_valid = v0; bus.req0_wEn = w0; bus.req0_addr = a0; bus.req0_wdata = d0;
    bus.req1_valid = v1; bus.req1_wEn = w1; bus.req1_addr = a1; bus.req1_wdata = d1;
  endtask

  task automatic idle();
    set_req(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(1, 1, 12'h123, 32'hCAFE0001, 1, 1, 12'h456, 32'hCAFE0002);
    @(negedge clk);
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %b exp 0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got %b exp 0", bus.req1_ready); end
    checks++; if (bus.mem_wEn !== 1'b0) begin errors++; $display("FAIL rst_mem_wEn got %b exp 0", bus.mem_wEn); end
    checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", bus.mem_addr); end
    checks++; if (bus.mem_dataIn !== '0) begin errors++; $display("FAIL rst_mem_dataIn got %h exp 0", bus.mem_dataIn); end
    checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b exp 00", {bus.rsp0_valid, bus.rsp1_valid}); end
    checks++; if ({bus.rsp0_rdata, bus.rsp1_rdata} !== '0) begin errors++; $display("FAIL rst_rdata got %h exp 0", {bus.rsp0_rdata, bus.rsp1_rdata}); end
    tick();
    apply_reset();
  endtask

  task automatic test_write_read();
    set_req(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, '0, '0);
    @(negedge clk);
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL wr_ready0 got %b exp 1", bus.req0_ready); end
    checks++; if ({bus.mem_wEn, bus.mem_addr, bus.mem_dataIn} !== {1'b1, 12'h010, 32'hDEADBEEF}) begin errors++; $display("FAIL wr_mem_drive got %b %h %h exp 1 010 deadbeef", bus.mem_wEn, bus.mem_addr, bus.mem_dataIn); end
    tick();
    set_req(1, 0, 12'h010, '0, 0, 0, '0, '0);
    @(negedge clk);
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rd_ready0 got %b exp 1", bus.req0_ready); end
    checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL wr_no_rsp got %b exp 0", bus.rsp0_valid); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp0_valid got %b exp 1", bus.rsp0_valid); end
    checks++; if (bus.rsp0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rsp0_rdata got %h exp deadbeef", bus.rsp0_rdata); end
    checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp1_quiet got %b exp 0", bus.rsp1_valid); end
    tick();
    @(negedge clk);
    checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp0_single got %b exp 0", bus.rsp0_valid); end
    tick();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    preload(12'h001, 32'h11111111);
    preload(12'h002, 32'h22222222);
    set_req(1, 0, 12'h001, '0, 1, 0, 12'h002, '0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) idle();
      @(negedge clk);
      if (i < 4) begin
        checks++; if ({bus.req0_ready, bus.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL sim_grant cyc %0d got %b%b", i, bus.req0_ready, bus.req1_ready); end
      end
      if (i > 0) begin
        checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL sim_rsp_valid cyc %0d got %b%b", i, bus.rsp0_valid, bus.rsp1_valid); end
        checks++; if ((bus.rsp0_rdata | bus.rsp1_rdata) !== ((i % 2 == 1) ? 32'h11111111 : 32'h22222222)) begin errors++; $display("FAIL sim_rsp_data cyc %0d got %h/%h", i, bus.rsp0_rdata, bus.rsp1_rdata); end
      end
      tick();
    end
`ifdef MEM_ARB_CONFLICT_CNT_EN
    checks++; if (conflict_cnt !== 16'd4) begin errors++; $display("FAIL sim_conflict_cnt got %0d exp 4", conflict_cnt); end
`endif
  endtask

  task automatic test_single_port();
    logic [DW-1:0] top_val;
    top_val = $urandom;
    preload(12'hFFF, top_val);
    set_req(1, 0, 12'h001, '0, 0, 0, '0, '0);
    tick();
    idle();
    tick();
    set_req(0, 0, '0, '0, 1, 0, 12'hFFF, '0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) idle();
      @(negedge clk);
      if (i < 3) begin
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL top_ready1 cyc %0d got %b exp 1", i, bus.req1_ready); end
        checks++; if (bus.mem_addr !== 12'hFFF) begin errors++; $display("FAIL top_addr cyc %0d got %h exp fff", i, bus.mem_addr); end
      end
      if (i > 0) begin
        checks++; if ({bus.rsp1_valid, bus.rsp1_rdata} !== {1'b1, top_val}) begin errors++; $display("FAIL top_rsp1 cyc %0d got %b %h exp 1 %h", i, bus.rsp1_valid, bus.rsp1_rdata, top_val); end
      end
      tick();
    end
    set_req(1, 0, 12'h001, '0, 1, 0, 12'h002, '0);
    @(negedge clk);
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL top_prio_end got %b%b exp 10", bus.req0_ready, bus.req1_ready); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_mixed_conflict();
    apply_reset();
    set_req(1, 1, 12'h020, 32'hA5A5A5A5, 1, 0, 12'h020, '0);
    @(negedge clk);
    checks++; if ({bus.req0_ready, bus.req1_ready, bus.mem_wEn} !== 3'b101) begin errors++; $display("FAIL mix_first got %b%b%b exp 101", bus.req0_ready, bus.req1_ready, bus.mem_wEn); end
    tick();
    set_req(0, 0, '0, '0, 1, 0, 12'h020, '0);
    @(negedge clk);
    checks++; if ({bus.req1_ready, bus.mem_wEn, bus.mem_addr} !== {2'b10, 12'h020}) begin errors++; $display("FAIL mix_second got %b%b %h exp 10 020", bus.req1_ready, bus.mem_wEn, bus.mem_addr); end
    tick();
    idle();
    @(negedge clk);
    checks++; if ({bus.rsp1_valid, bus.rsp1_rdata} !== {1'b1, 32'hA5A5A5A5}) begin errors++; $display("FAIL mix_rsp1 got %b %h exp 1 a5a5a5a5", bus.rsp1_valid, bus.rsp1_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(1, 0, 12'h001, '0, 0, 0, '0, '0);
    tick();
    set_req(0, 0, '0, '0, 1, 0, 12'h002, '0);
    @(negedge clk);
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready1 got %b exp 1", bus.req1_ready); end
    tick();
    reset = 1'b1;
    set_req(1, 1, 12'h030, 32'h1, 1, 1, 12'h031, 32'h2);
    @(negedge clk);
    checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp1_dropped got %b exp 0", bus.rsp1_valid); end
    checks++; if ({bus.req0_ready, bus.req1_ready, bus.mem_wEn} !== 3'b000) begin errors++; $display("FAIL rmid_quiet got %b%b%b exp 000", bus.req0_ready, bus.req1_ready, bus.mem_wEn); end
    tick();
    reset = 1'b0;
    set_req(1, 0, 12'h001, '0, 1, 0, 12'h002, '0);
    @(negedge clk);
    checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL rmid_after_rsp1 got %b exp 0", bus.rsp1_valid); end
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL rmid_prio got %b%b exp 10", bus.req0_ready, bus.req1_ready); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_idle();
    set_req(1, 0, 12'h002, '0, 0, 0, '0, '0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({bus.mem_wEn, bus.mem_addr, bus.req0_ready, bus.req1_ready} !== '0) begin errors++; $display("FAIL idle_drive cyc %0d got %b %h %b%b exp 0", i, bus.mem_wEn, bus.mem_addr, bus.req0_ready, bus.req1_ready); end
      checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== ((i == 0) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL idle_rsp cyc %0d got %b%b", i, bus.rsp0_valid, bus.rsp1_valid); end
      tick();
    end
    set_req(1, 0, 12'h001, '0, 1, 0, 12'h002, '0);
    @(negedge clk);
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin errors++; $display("FAIL idle_prio_kept got %b%b exp 01", bus.req0_ready, bus.req1_ready); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [0:7];
    int g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic ew;
    for (int k = 0; k < 7; k++) pool[k] = AW'(k * 5);
    pool[7] = 12'hFFF;
    for (int k = 0; k < 8; k++) preload(pool[k], $urandom);
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      set_req($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pool[$urandom_range(0, 7)], $urandom,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pool[$urandom_range(0, 7)], $urandom);
      @(negedge clk);
      g  = model_grant();
      ew = (g == 0) ? bus.req0_wEn : (g == 1) ? bus.req1_wEn : 1'b0;
      ea = (g == 0) ? bus.req0_addr : (g == 1) ? bus.req1_addr : '0;
      ed = (g == 0) ? bus.req0_wdata : (g == 1) ? bus.req1_wdata : '0;
      checks++; if ({bus.req0_ready, bus.req1_ready} !== {g == 0, g == 1}) begin errors++; $display("FAIL rnd_ready cyc %0d got %b%b exp grant %0d", i, bus.req0_ready, bus.req1_ready, g); end
      checks++; if ({bus.mem_wEn, bus.mem_addr, bus.mem_dataIn} !== {ew, ea, ed}) begin errors++; $display("FAIL rnd_mem cyc %0d got %b %h %h exp %b %h %h", i, bus.mem_wEn, bus.mem_addr, bus.mem_dataIn, ew, ea, ed); end
      checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== {!reset && m_pend && m_id == 0, !reset && m_pend && m_id == 1}) begin errors++; $display("FAIL rnd_rsp_valid cyc %0d got %b%b exp pend %0d id %0d", i, bus.rsp0_valid, bus.rsp1_valid, m_pend, m_id); end
      checks++; if ((bus.rsp0_rdata | bus.rsp1_rdata) !== ((!reset && m_pend) ? m_pdata : '0)) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h/%h exp %h", i, bus.rsp0_rdata, bus.rsp1_rdata, m_pdata); end
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
`ifdef MEM_ARB_CONFLICT_CNT_EN
    checks++; if (conflict_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_conflict_cnt got %0d exp %0d", conflict_cnt, m_cnt); end
`endif
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_simultaneous();
    test_single_port();
    test_mixed_conflict();
    test_reset_mid();
    test_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous instruction/data memory between two requesters, e.g. the CPU data port and the sprite/VGA fetch logic.
- The memory port has these semantics:
  - Address is sampled on the rising edge of `clk`.
  - When `wEn`=1 the location is written and `dataOut` holds its previous value.
  - When `wEn`=0, `dataOut` presents the location one cycle later.
- The block does round-robin arbitration with a valid/ready handshake per requester.
- It routes the registered read data back to the requester that issued the read.

Parameters:
- `DATA_WIDTH`, 32, width of the memory word and the write/read data.
- `ADDRESS_WIDTH`, 12, width of the memory address.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a request.
- `req0_wEn`  in  1  requester 0 request is a write (1) or a read (0).
- `req0_addr`  in  `ADDRESS_WIDTH`  requester 0 address.
- `req0_wdata`  in  `DATA_WIDTH`  requester 0 write data.
- `req0_ready`  out  1  requester 0 request accepted this cycle.
- `rsp0_valid`  out  1  requester 0 read data valid.
- `rsp0_rdata`  out  `DATA_WIDTH`  requester 0 read data.
- `req1_*` / `rsp1_*`: same set, widths and meanings as port 0, for requester 1.
- `mem_wEn`  out  1  to memory `wEn`.
- `mem_addr`  out  `ADDRESS_WIDTH`  to memory `addr`.
- `mem_dataIn`  out  `DATA_WIDTH`  to memory `dataIn`.
- `mem_dataOut`  in  `DATA_WIDTH`  from memory `dataOut`.

Behaviour:
- **State:**
  - `prio`: 1 bit, the port favoured on a conflict.
  - `rsp_pend`: 1 bit, a read was issued last cycle.
  - `rsp_id`: 1 bit, the port that issued it.
- **Reset values:**
  - `prio`=0, `rsp_pend`=0, `rsp_id`=0.
  - While `reset`=1: `req0_ready`=`req1_ready`=0, `mem_wEn`=0, `mem_addr`=0, `mem_dataIn`=0, `rsp0_valid`=`rsp1_valid`=0, `rsp*_rdata`=0.
- **Grant rules (combinational, same cycle):**
  - Only `reqN_valid` high: grant N.
  - Both high: grant `prio`.
  - Neither high: no grant.
- **Handshake:**
  - `reqN_ready` = grant to N; it depends on `reqN_valid` (valid→ready combinational path is permitted).
  - A transfer occurs when valid and ready are both high.
  - Requesters hold valid, `wEn`, `addr` and `wdata` stable until ready.
- **Memory drive:**
  - On grant N: `mem_wEn`=`reqN_wEn`, `mem_addr`=`reqN_addr`, `mem_dataIn`=`reqN_wdata`.
  - No grant: all three driven to 0. This is an idle read of address 0, and its data is discarded.
- **Priority update:**
  - After any grant to N, `prio` <= 1-N.
  - No grant: `prio` unchanged.
- **Read response:**
  - A granted read in cycle t sets `rsp_pend`=1 and `rsp_id`=N at edge t.
  - In cycle t+1: `rspN_valid`=1 for exactly one cycle, `rspN_rdata`=`mem_dataOut`.
  - The other port's `rdata` is 0.
  - Latency is exactly 1 cycle. Throughput is one request per cycle, with back-to-back reads on the same or alternating ports.
- **Writes:** a granted write produces no response. `rsp_pend` <= 0 unless a read was granted that cycle.
- **Boundary cases:**
  - A read immediately following a write to the same address returns the new data, because memory writes at edge t and reads at edge t+1.
  - The top address 2^`ADDRESS_WIDTH`-1 is used as-is; there is no wrap logic.
  - `reset` asserted the cycle after a read grant drops that response: `rspN_valid` stays 0.
  - A requester dropping valid before ready is tolerated: nothing is issued for it.

Optional Feature:
- Macro: `MEM_ARB_CONFLICT_CNT_EN`.
- **Defined:**
  - Adds output `conflict_cnt` [15:0].
  - It increments on every non-reset cycle with `req0_valid`=`req1_valid`=1.
  - It saturates at 16'hFFFF and is 0 on reset.
- **Undefined:** the port and counter are absent; arbitration behaviour is identical either way.

Test Plan:
- **Single write/read:** port 0 write addr 0x010 data 0xDEADBEEF, next cycle port 0 read 0x010 → `req0_ready`=1 both cycles; `rsp0_valid`=1 one cycle after the read with 0xDEADBEEF; `rsp1_valid` stays 0.
- **Simultaneous reads:** after reset, both ports read (port 0 addr 0x001 = 0x11111111, port 1 addr 0x002 = 0x22222222) continuously for 4 cycles:
  - Grants alternate 0,1,0,1.
  - Responses alternate `rsp0` 0x11111111 / `rsp1` 0x22222222.
  - `conflict_cnt`=4 when the macro is defined.
- **Single active requester:** only port 1 reads addr 0xFFF every cycle for 3 cycles → `req1_ready`=1 every cycle; 3 consecutive `rsp1_valid` pulses with `mem[0xFFF]`; `prio` ends at 0.
- **Mixed write/read under conflict:** port 0 write addr 0x020 = 0xA5A5A5A5 while port 1 reads addr 0x020 with `prio`=0 → write granted first; port 1 granted next cycle and receives 0xA5A5A5A5.
- **Reset mid-operation:** port 1 read granted, then `reset`=1 the next cycle → `rsp1_valid`=0; all `ready` and `mem_wEn` = 0 during reset; `prio`=0 after release.
- **Idle:** no valids for 5 cycles → `mem_wEn`=0, `mem_addr`=0, no `rsp_valid`, `prio` unchanged.
